// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit game PRN link (x^10+x^9+1).
// Holds LFSR geometry, default seed, checker states and next-bit function.
package lfsr_pkg;

   localparam int LFSR_W = 10;
   localparam int TAP_A  = 9;
   localparam int TAP_B  = 8;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 10'd88;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // b[n+10] = b[n] ^ b[n+1]: the two oldest history bits
   function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] hist);
      return hist[TAP_A] ^ hist[TAP_B];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear applies before increment.
// Ports: clk, rst (async active-low), clr, inc, cnt[W-1:0].
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] base;

   always_comb begin
      base = clr ? '0 : cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (inc && (base != '1)) begin
         cnt <= base + W'(1);
      end else begin
         cnt <= base;
      end
   end

endmodule

// File: rtl/lfsr_10bit_checker.sv
// Self-synchronising checker for the serial 10-bit PRN stream; counts errors.
// Ports: clk, rst (async active-low), bit_valid, bit_in, clr_err -> locked,
//   state, err_pulse, err_cnt; bit_cnt added when LFSR_CHK_BITCNT_EN is defined.
module lfsr_10bit_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 4,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clr_err,
`ifdef LFSR_CHK_BITCNT_EN
   output logic [ERR_W-1:0] bit_cnt,
`endif
   output logic             locked,
   output logic [1:0]       state,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int FW = $clog2(LFSR_W);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   localparam logic [FW-1:0] FILL_LAST = FW'(LFSR_W - 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CNT - 1);

   chk_state_t        st;
   logic [LFSR_W-1:0] hist;
   logic [FW-1:0]     fill;
   logic [MW-1:0]     match;
   logic [LW-1:0]     miss;

   logic exp_bit;
   logic mism;
   logic hist_zero;
   logic cmp_inc;
   logic err_inc;

   always_comb begin
      exp_bit   = lfsr_next_bit(hist);
      mism      = bit_in ^ exp_bit;
      hist_zero = (hist == '0);
      cmp_inc   = bit_valid && (st == LOCKED);
      err_inc   = cmp_inc && mism;
   end

   assign state = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         match     <= '0;
         miss      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (bit_valid) begin
            unique case (st)
               SEARCH: begin
                  hist <= {hist[LFSR_W-2:0], bit_in};
                  if (fill == FILL_LAST) begin
                     st    <= VERIFY;
                     fill  <= '0;
                     match <= '0;
                  end else begin
                     fill <= fill + FW'(1);
                  end
               end
               VERIFY: begin
                  hist <= {hist[LFSR_W-2:0], bit_in};
                  // an all-zero history would "match" a dead stream forever
                  if (!mism && !hist_zero) begin
                     if (match == LOCK_LAST) begin
                        st     <= LOCKED;
                        locked <= 1'b1;
                        miss   <= '0;
                     end else begin
                        match <= match + MW'(1);
                     end
                  end else begin
                     match <= '0;
                  end
               end
               LOCKED: begin
                  // free-run on our own prediction so line errors stay isolated
                  hist <= {hist[LFSR_W-2:0], exp_bit};
                  if (mism) begin
                     err_pulse <= 1'b1;
                     if (miss == LOSS_LAST) begin
                        st     <= SEARCH;
                        locked <= 1'b0;
                        hist   <= '0;
                        fill   <= '0;
                        miss   <= '0;
                     end else begin
                        miss <= miss + LW'(1);
                     end
                  end else begin
                     miss <= '0;
                  end
               end
               default: begin
                  st     <= SEARCH;
                  locked <= 1'b0;
                  hist   <= '0;
                  fill   <= '0;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W(ERR_W)
   ) u_err_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr_err),
      .inc(err_inc),
      .cnt(err_cnt)
   );

`ifdef LFSR_CHK_BITCNT_EN
   sat_counter #(
      .W(ERR_W)
   ) u_bit_cnt (
      .clk(clk),
      .rst(rst),
      .clr(clr_err),
      .inc(cmp_inc),
      .cnt(bit_cnt)
   );
`else
   logic unused_cmp;
   assign unused_cmp = cmp_inc;
`endif

endmodule

// File: tb/tb_lfsr_10bit_checker.sv
// Scoreboard bench for lfsr_10bit_checker with a queue-based reference model.
// Optional bit_cnt checks follow LFSR_CHK_BITCNT_EN.
module tb_lfsr_10bit_checker;

   localparam int LOCK_CNT = 16;
   localparam int LOSS_CNT = 4;
   localparam int ERR_W    = 4;
   localparam int CMAX     = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic             clr_err = 1'b0;
   logic             locked;
   logic [1:0]       state;
   logic             err_pulse;
   logic [ERR_W-1:0] err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
   logic [ERR_W-1:0] bit_cnt;
`endif

   always #5 clk = ~clk;

   lfsr_10bit_checker #(
      .LOCK_CNT(LOCK_CNT),
      .LOSS_CNT(LOSS_CNT),
      .ERR_W(ERR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bit_valid(bit_valid),
      .bit_in(bit_in),
      .clr_err(clr_err),
`ifdef LFSR_CHK_BITCNT_EN
      .bit_cnt(bit_cnt),
`endif
      .locked(locked),
      .state(state),
      .err_pulse(err_pulse),
      .err_cnt(err_cnt)
   );

   typedef struct {
      int lk;
      int st;
      int ep;
      int ec;
      int bc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // reference model: window of the last ten bits, oldest first
   int m_st;
   bit m_win[$];
   int m_match, m_miss, m_ec, m_bc;
   int m_pulse;

   // generator: b[n+10] = b[n] ^ b[n+1], seeded with 88
   bit g[$];

   task automatic chk(input string nm, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
      end
   endtask

   task automatic gen_bit(output bit b);
      bit nb;
      b  = g[0];
      nb = g[0] ^ g[1];
      void'(g.pop_front());
      g.push_back(nb);
   endtask

   task automatic model_step(input bit v, input bit b, input bit c, input bit r);
      bit e;
      bit z;
      if (!r) begin
         m_st = 0; m_win.delete(); m_match = 0; m_miss = 0;
         m_ec = 0; m_bc = 0; m_pulse = 0;
         return;
      end
      m_pulse = 0;
      if (c) begin
         m_ec = 0;
         m_bc = 0;
      end
      if (!v) return;
      if (m_st == 0) begin
         m_win.push_back(b);
         if (m_win.size() == 10) begin
            m_st = 1;
            m_match = 0;
         end
         return;
      end
      e = m_win[0] ^ m_win[1];
      z = 1'b1;
      foreach (m_win[i]) if (m_win[i]) z = 1'b0;
      void'(m_win.pop_front());
      if (m_st == 1) begin
         if (b == e && !z) m_match++;
         else m_match = 0;
         m_win.push_back(b);
         if (m_match == LOCK_CNT) begin
            m_st = 2;
            m_miss = 0;
         end
      end else begin
         if (m_bc < CMAX) m_bc++;
         if (b != e) begin
            m_pulse = 1;
            if (m_ec < CMAX) m_ec++;
            m_miss++;
         end else begin
            m_miss = 0;
         end
         m_win.push_back(e);
         if (m_miss == LOSS_CNT) begin
            m_st = 0;
            m_win.delete();
         end
      end
   endtask

   task automatic drive(input bit v, input bit b, input bit c, input bit r);
      exp_t x;
      @(negedge clk);
      bit_valid = v;
      bit_in    = b;
      clr_err   = c;
      rst       = r;
      model_step(v, b, c, r);
      x.lk = (m_st == 2) ? 1 : 0;
      x.st = m_st;
      x.ep = m_pulse;
      x.ec = m_ec;
      x.bc = m_bc;
      sb.push_back(x);
   endtask

   // one valid bit preceded by gap-1 idle cycles
   task automatic send(input bit flip, input bit c, input int gap);
      bit b;
      for (int i = 1; i < gap; i++) drive(1'b0, 1'($urandom), 1'b0, 1'b1);
      gen_bit(b);
      drive(1'b1, b ^ flip, c, 1'b1);
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1);
   endtask

   task automatic lock_count(input int gap, output int cnt);
      cnt = 0;
      while (cnt < 100) begin
         send(1'b0, 1'b0, gap);
         cnt++;
         @(posedge clk);
         #1;
         if (locked) break;
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0);
   endtask

   // monitor: compares every presented output against the queued expectation
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("locked", int'(locked), x.lk);
            chk("state", int'(state), x.st);
            chk("err_pulse", int'(err_pulse), x.ep);
            chk("err_cnt", int'(err_cnt), x.ec);
`ifdef LFSR_CHK_BITCNT_EN
            chk("bit_cnt", int'(bit_cnt), x.bc);
`endif
         end
      end
   end

   initial begin
      int cnt;
      logic [9:0] seed;
      seed = 10'd88;
      for (int i = 0; i < 10; i++) g.push_back(seed[i]);
      model_step(1'b0, 1'b0, 1'b0, 1'b0);

      do_reset(8);

      lock_count(1, cnt);
      chk("lock_at_26", cnt, 26);
      clean(2046);
      chk("clean_err0", int'(err_cnt), 0);

      do_reset(2);
      lock_count(3, cnt);
      chk("lock_gap3_26", cnt, 26);

      clean(99);
      send(1'b1, 1'b0, 1);
      clean(30);
      chk("single_err", int'(err_cnt), 1);
      chk("single_lock", int'(locked), 1);

      send(1'b0, 1'b1, 1);
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1);
      @(posedge clk);
      #1;
      chk("loss_unlock", int'(locked), 0);
      lock_count(1, cnt);
      chk("relock_26", cnt, 26);
      chk("loss_errs", int'(err_cnt), 4);

      do_reset(2);
      for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
      chk("zero_nolock", int'(locked), 0);
      clean(100);
      chk("zero_relock", int'(locked), 1);

      send(1'b0, 1'b1, 1);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 1'b0, 1);
         clean(5);
      end
      chk("err_sat", int'(err_cnt), CMAX);
      send(1'b1, 1'b1, 1);
      @(posedge clk);
      #1;
      chk("clr_plus_err", int'(err_cnt), 1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) begin
            drive(1'b1, 1'($urandom), 1'b0, 1'b0);
         end else if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 1'($urandom), 1'($urandom_range(0, 99) == 0), 1'b1);
         end else begin
            send(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) == 0), 1);
         end
      end

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
